// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
//   Types and default sizes shared by the convolution operand loader and the
//   convolution controller.
//   - loader_state_t : operand-loader FSM state encoding
//   - DEF_*          : default word width and map/kernel dimensions
//   - cnt_width()    : counter width helper that never returns zero
// ----------------------------------------------------------------------------
package conv_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_IFM_SIZE = 8;
    localparam int DEF_K_SIZE   = 3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD_IFM = 2'd1,
        S_LOAD_WGT = 2'd2
    } loader_state_t;

    // Width of a counter that must hold the values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_ifm_buffer.sv
// ----------------------------------------------------------------------------
// conv_ifm_buffer
//   Single-write-port, single-registered-read-port feature-map RAM.
//   The read is read-before-write: a read and a write to the same address in
//   the same cycle return the value held before the write.
// Ports
//   clk        in   1       system clock
//   reset      in   1       synchronous active-high; clears the read register only
//   i_wr_en    in   1       write strobe
//   i_wr_addr  in   AW      write address
//   i_wr_data  in   DATA_W  write data
//   i_rd_addr  in   AW      read address, sampled every cycle
//   o_rd_data  out  DATA_W  read data, one cycle after i_rd_addr
// ----------------------------------------------------------------------------
module conv_ifm_buffer
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_IFM_SIZE * DEF_IFM_SIZE,
    parameter int AW     = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // NOTE: the storage array has no reset so it maps onto block RAM; only the
    // output register is cleared.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // NOTE: non-blocking assignments make the read sample r_mem before this
    // edge's write lands, which is exactly the read-before-write behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/conv_operand_loader.sv
// ----------------------------------------------------------------------------
// conv_operand_loader
//   Operand stage ahead of the convolution controller. After load_start it
//   takes IFM_SIZE*IFM_SIZE pixels followed by K_SIZE*K_SIZE weights from one
//   valid/ready stream, keeps the pixels in conv_ifm_buffer and the weights in
//   registers, and pulses finish_getting_input / finish_getting_weight one
//   cycle after the last word of each phase is accepted.
// Ports
//   clk                    in   1                     system clock
//   reset                  in   1                     synchronous active-high reset
//   load_start             in   1                     start a load (honoured in S_IDLE only)
//   in_valid               in   1                     stream word valid
//   in_data                in   DATA_W                stream word: pixels, then weights
//   in_ready               out  1                     word accepted when in_valid is also high
//   busy                   out  1                     a load is in progress
//   finish_getting_input   out  1                     pulse: last pixel was accepted
//   finish_getting_weight  out  1                     pulse: last weight was accepted
//   ifm_raddr              in   IFM_AW                feature-map read address
//   ifm_rdata              out  DATA_W                feature-map data, 1-cycle latency
//   wgt_flat               out  K_SIZE*K_SIZE*DATA_W  weight i at [i*DATA_W +: DATA_W]
// ----------------------------------------------------------------------------
module conv_operand_loader
    import conv_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IFM_SIZE = DEF_IFM_SIZE,
    parameter int K_SIZE   = DEF_K_SIZE,
    parameter int IFM_AW   = $clog2(IFM_SIZE * IFM_SIZE)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load_start,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    output logic                             busy,
    output logic                             finish_getting_input,
    output logic                             finish_getting_weight,
    input  logic [IFM_AW-1:0]                ifm_raddr,
    output logic [DATA_W-1:0]                ifm_rdata,
    output logic [K_SIZE*K_SIZE*DATA_W-1:0]  wgt_flat
);

    localparam int NPIX   = IFM_SIZE * IFM_SIZE;
    localparam int NWGT   = K_SIZE * K_SIZE;
    localparam int WGT_CW = cnt_width(NWGT);

    localparam logic [IFM_AW-1:0] PIX_LAST = IFM_AW'(NPIX - 1);
    localparam logic [WGT_CW-1:0] WGT_LAST = WGT_CW'(NWGT - 1);

    loader_state_t              r_state;
    logic [IFM_AW-1:0]          r_pix_cnt;
    logic [WGT_CW-1:0]          r_wgt_cnt;
    logic                       r_fin_in;
    logic                       r_fin_wgt;
    logic [NWGT*DATA_W-1:0]     r_wgt_flat;

    logic                       w_accept;
    logic                       w_ifm_we;

    // Ready depends on state alone so the upstream may wait for ready before
    // raising valid without creating a combinational loop.
    assign in_ready = (r_state != S_IDLE);
    assign busy     = (r_state != S_IDLE);

    assign w_accept = in_valid && in_ready;
    assign w_ifm_we = w_accept && (r_state == S_LOAD_IFM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pix_cnt  <= '0;
            r_wgt_cnt  <= '0;
            r_fin_in   <= 1'b0;
            r_fin_wgt  <= 1'b0;
            r_wgt_flat <= '0;
        end else begin
            // Finish flags are single-cycle pulses unless re-armed below.
            r_fin_in  <= 1'b0;
            r_fin_wgt <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state   <= S_LOAD_IFM;
                        r_pix_cnt <= '0;
                    end
                end

                S_LOAD_IFM: begin
                    if (w_accept) begin
                        if (r_pix_cnt == PIX_LAST) begin
                            // Counter parks at its terminal value; it is
                            // cleared again on the next entry from S_IDLE.
                            r_state   <= S_LOAD_WGT;
                            r_wgt_cnt <= '0;
                            r_fin_in  <= 1'b1;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                end

                S_LOAD_WGT: begin
                    if (w_accept) begin
                        r_wgt_flat[r_wgt_cnt*DATA_W +: DATA_W] <= in_data;
                        if (r_wgt_cnt == WGT_LAST) begin
                            // load_start seen in this same cycle is dropped:
                            // the FSM is not in S_IDLE when it is sampled.
                            r_state   <= S_IDLE;
                            r_fin_wgt <= 1'b1;
                        end else begin
                            r_wgt_cnt <= r_wgt_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign finish_getting_input  = r_fin_in;
    assign finish_getting_weight = r_fin_wgt;
    assign wgt_flat              = r_wgt_flat;

    conv_ifm_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (NPIX),
        .AW     (IFM_AW)
    ) u_ifm_buffer (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_ifm_we),
        .i_wr_addr (r_pix_cnt),
        .i_wr_data (in_data),
        .i_rd_addr (ifm_raddr),
        .o_rd_data (ifm_rdata)
    );

endmodule

// File: tb/tb_conv_operand_loader.sv
// ----------------------------------------------------------------------------
// tb_conv_operand_loader
//   Self-checking bench for conv_operand_loader. A behavioural model holds the
//   expected feature map and weights as plain arrays; stream words are indexed
//   by how many have been accepted, so the expected finish pulses, read data
//   and weights follow directly from the stream order.
// ----------------------------------------------------------------------------
module tb_conv_operand_loader;
    import conv_pkg::*;

    localparam int DATA_W   = 8;
    localparam int IFM_SIZE = 8;
    localparam int K_SIZE   = 3;
    localparam int IFM_AW   = 6;
    localparam int NPIX     = IFM_SIZE * IFM_SIZE;
    localparam int NWGT     = K_SIZE * K_SIZE;
    localparam int NWORDS   = NPIX + NWGT;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      load_start;
    logic                      in_valid;
    logic [DATA_W-1:0]         in_data;
    logic                      in_ready;
    logic                      busy;
    logic                      fin_in;
    logic                      fin_wgt;
    logic [IFM_AW-1:0]         ifm_raddr;
    logic [DATA_W-1:0]         ifm_rdata;
    logic [NWGT*DATA_W-1:0]    wgt_flat;

    always #5 clk = ~clk;

    conv_operand_loader #(
        .DATA_W   (DATA_W),
        .IFM_SIZE (IFM_SIZE),
        .K_SIZE   (K_SIZE),
        .IFM_AW   (IFM_AW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .load_start            (load_start),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .in_ready              (in_ready),
        .busy                  (busy),
        .finish_getting_input  (fin_in),
        .finish_getting_weight (fin_wgt),
        .ifm_raddr             (ifm_raddr),
        .ifm_rdata             (ifm_rdata),
        .wgt_flat              (wgt_flat)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [DATA_W-1:0] m_ifm   [NPIX];
    bit                m_known [NPIX];
    logic [DATA_W-1:0] m_wgt   [NWGT];
    logic [DATA_W-1:0] words   [NWORDS];

    task automatic check(input string tag, input logic [NWGT*DATA_W-1:0] obs,
                         input logic [NWGT*DATA_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NWGT*DATA_W-1:0] exp_flat();
        logic [NWGT*DATA_W-1:0] f;
        for (int i = 0; i < NWGT; i++) f[i*DATA_W +: DATA_W] = m_wgt[i];
        return f;
    endfunction

    // Outputs are observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: valid always high, 1: valid every other cycle (starting low),
    // 2: random valid. glitch_at: hold load_start while that word index is
    // pending. start_at_end: raise load_start with the final weight.
    task automatic do_load(input int mode, input int glitch_at,
                           input bit start_at_end, input bit raddr5);
        int acc;
        int cyc;
        bit v;
        bit exp_fi;
        bit exp_fw;
        bit rd_known;
        logic [IFM_AW-1:0] ra;
        logic [DATA_W-1:0] exp_rd;

        load_start = 1'b1;
        in_valid   = 1'b0;
        tick();
        load_start = 1'b0;
        check("start_busy", busy, 1);
        check("start_ready", in_ready, 1);

        acc = 0;
        cyc = 0;
        while (acc < NWORDS && cyc < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = $urandom_range(0, 1) == 1;
            endcase
            in_valid   = v;
            in_data    = v ? words[acc] : DATA_W'($urandom);
            load_start = (acc == glitch_at) || (start_at_end && acc == NWORDS - 1 && v);
            ra         = raddr5 ? IFM_AW'(5) : IFM_AW'($urandom_range(0, NPIX - 1));
            ifm_raddr  = ra;
            // Read returns the contents from before this cycle's write.
            exp_rd     = m_ifm[ra];
            rd_known   = m_known[ra];
            check("ready_in_load", in_ready, 1);
            exp_fi = v && (acc == NPIX - 1);
            exp_fw = v && (acc == NWORDS - 1);
            if (v) begin
                if (acc < NPIX) begin
                    m_ifm[acc]   = words[acc];
                    m_known[acc] = 1'b1;
                end else begin
                    m_wgt[acc - NPIX] = words[acc];
                end
                acc++;
            end
            tick();
            cyc++;
            load_start = 1'b0;
            check("fin_input", fin_in, exp_fi);
            check("fin_weight", fin_wgt, exp_fw);
            if (rd_known) check("rd_during_load", ifm_rdata, exp_rd);
        end
        in_valid = 1'b0;
        check("load_complete", acc, NWORDS);
        check("idle_busy", busy, 0);
        check("idle_ready", in_ready, 0);
        check("wgt_flat", wgt_flat, exp_flat());
        if (mode == 0) check("cycles_full", cyc, NWORDS);
        if (mode == 1) check("cycles_toggle", cyc, 2 * NWORDS);
        tick();
        check("post_fin_input", fin_in, 0);
        check("post_fin_weight", fin_wgt, 0);
        check("post_busy", busy, 0);
    endtask

    task automatic readback();
        for (int a = 0; a < NPIX; a++) begin
            ifm_raddr = IFM_AW'(a);
            tick();
            check("readback", ifm_rdata, m_ifm[a]);
        end
    endtask

    task automatic random_words(input logic [DATA_W-1:0] pix5);
        for (int i = 0; i < NWORDS; i++) words[i] = DATA_W'($urandom);
        words[5] = pix5;
    endtask

    initial begin
        logic [NWGT*DATA_W-1:0] f;

        for (int i = 0; i < NWGT; i++) m_wgt[i] = '0;
        reset      = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        ifm_raddr  = '0;
        repeat (3) tick();
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_fin_input", fin_in, 0);
        check("rst_fin_weight", fin_wgt, 0);
        check("rst_wgt_flat", wgt_flat, 0);
        check("rst_rdata", ifm_rdata, 0);
        reset = 1'b0;
        tick();
        check("idle_no_start", busy, 0);

        // Pixels 0..63 then weights 1..9, valid held high.
        for (int i = 0; i < NPIX; i++) words[i] = DATA_W'(i);
        for (int i = 0; i < NWGT; i++) words[NPIX + i] = DATA_W'(i + 1);
        do_load(0, -1, 1'b0, 1'b0);
        f = wgt_flat;
        check("wgt0_is_1", f[7:0], 1);
        check("wgt8_is_9", f[71:64], 9);
        ifm_raddr = IFM_AW'(10);
        tick();
        check("raddr10", ifm_rdata, 10);
        readback();

        // Toggled valid; load_start while pixel 20 is pending must be ignored.
        random_words(8'h11);
        do_load(1, 20, 1'b0, 1'b0);
        readback();

        // Overwrite pixel 5 (old 0x11) while reading address 5 continuously;
        // load_start coincides with the final weight and must be ignored.
        random_words(8'hAA);
        do_load(0, -1, 1'b1, 1'b1);
        ifm_raddr = IFM_AW'(5);
        tick();
        check("pix5_new", ifm_rdata, 8'hAA);
        readback();

        // Reset with 30 pixels accepted.
        random_words(8'h5C);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            m_ifm[i]   = words[i];
            m_known[i] = 1'b1;
            tick();
            check("partial_fin_input", fin_in, 0);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NWGT; i++) m_wgt[i] = '0;
        check("midrst_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wgt_flat", wgt_flat, 0);
        check("midrst_rdata", ifm_rdata, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_fin_input", fin_in, 0);
            check("midrst_fin_weight", fin_wgt, 0);
            check("midrst_idle", busy, 0);
        end

        // Fresh load after the reset, random valid.
        random_words(8'h3E);
        do_load(2, -1, 1'b0, 1'b0);
        readback();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
